// File: rtl/page_stack_ctl_if.sv
// page_stack_ctl_if: CPU bus and interrupt-pulse bundle for the page-stack controller.
//   AD       register address within the peripheral window
//   DI / DO  write data from the CPU / registered read data
//   rw, cs   1 = read / 0 = write; access valid while cs is high
//   irq_ack  one-cycle pulse on interrupt vector fetch
//   rti_done one-cycle pulse on RTI completion
//   page     current memory page to the address decoder
//   stk_err  high while an overflow or underflow flag is set
// master = CPU side, slave = controller side.
interface page_stack_ctl_if;
  logic [4:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic       irq_ack;
  logic       rti_done;
  logic [4:0] page;
  logic       stk_err;

  modport master (output AD, DI, rw, cs, irq_ack, rti_done,
                  input  DO, page, stk_err);
  modport slave  (input  AD, DI, rw, cs, irq_ack, rti_done,
                  output DO, page, stk_err);
endinterface

// File: rtl/page_stack_ctl.sv
// page_stack_ctl: page-select register with a hardware page stack.
// An interrupt vector fetch pushes the current page and switches to the
// programmable interrupt page; RTI completion pops it back.
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   bus      page_stack_ctl_if.slave (register access, pulses, page/stk_err out)
// Registers: 10000 page[3:0], 10001 page[4], 10010 STATUS
// {EN,UDF,OVF,0,depth}, 10011 IRQPAGE.
module page_stack_ctl #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  page_stack_ctl_if.slave         bus
);

  localparam logic [4:0] A_PG_LO  = 5'b10000;
  localparam logic [4:0] A_PG_HI  = 5'b10001;
  localparam logic [4:0] A_STATUS = 5'b10010;
  localparam logic [4:0] A_IRQPG  = 5'b10011;

  logic [4:0] page_q, page_d;
  logic [7:0] do_q, do_d;
  logic [3:0] depth_q, depth_d;
  logic       ovf_q, ovf_d;
  logic       udf_q, udf_d;
  logic       en_q, en_d;
  logic [4:0] irq_page_q, irq_page_d;
  logic [4:0] stack_q [DEPTH];
  logic [4:0] stack_d [DEPTH];

  logic wr, rd, push, pop, both;
  logic [4:0] top;

  assign wr   = bus.cs & ~bus.rw;
  assign rd   = bus.cs & bus.rw;
  assign push = en_q & bus.irq_ack & ~bus.rti_done;
  assign pop  = en_q & bus.rti_done & ~bus.irq_ack;
  assign both = en_q & bus.irq_ack & bus.rti_done;

  // Entry at depth-1; only meaningful when depth is non-zero.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (i + 1 == int'(depth_q)) top = stack_q[i];
  end

  always_comb begin
    page_d     = page_q;
    do_d       = do_q;
    depth_d    = depth_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    en_d       = en_q;
    irq_page_d = irq_page_q;
    stack_d    = stack_q;

    if (rd) begin
      case (bus.AD)
        A_PG_LO:  do_d = {4'b0, page_q[3:0]};
        A_PG_HI:  do_d = {7'b0, page_q[4]};
        A_STATUS: do_d = {en_q, udf_q, ovf_q, 1'b0, depth_q};
        A_IRQPG:  do_d = {3'b0, irq_page_q};
        default:  do_d = 8'h00;
      endcase
    end

    if (wr) begin
      case (bus.AD)
        A_PG_LO:  page_d[3:0] = bus.DI[3:0];
        A_PG_HI:  page_d[4]   = bus.DI[0];
        A_STATUS: begin
          en_d = bus.DI[7];
          if (bus.DI[6]) udf_d = 1'b0;
          if (bus.DI[5]) ovf_d = 1'b0;
        end
        A_IRQPG:  irq_page_d = bus.DI[4:0];
        default:  ;
      endcase
    end

    // Stack events come after the bus write so they override page and so a
    // flag set beats a same-cycle clear. All use the pre-edge irq_page/page.
    if (push) begin
      page_d = irq_page_q;
      if (depth_q < 4'(DEPTH)) begin
        for (int i = 0; i < DEPTH; i++)
          if (i == int'(depth_q)) stack_d[i] = page_q;
        depth_d = depth_q + 4'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (pop) begin
      if (depth_q != 4'd0) begin
        page_d  = top;
        depth_d = depth_q - 4'd1;
      end else begin
        page_d = page_q;
        udf_d  = 1'b1;
      end
    end else if (both) begin
      // Pop-then-push collapses to a page switch when the stack is non-empty.
      page_d = irq_page_q;
      if (depth_q == 4'd0) begin
        udf_d      = 1'b1;
        stack_d[0] = page_q;
        depth_d    = 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      page_q     <= '0;
      do_q       <= '0;
      depth_q    <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      en_q       <= 1'b0;
      irq_page_q <= '0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      page_q     <= page_d;
      do_q       <= do_d;
      depth_q    <= depth_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      en_q       <= en_d;
      irq_page_q <= irq_page_d;
      stack_q    <= stack_d;
    end
  end

  assign bus.page    = page_q;
  assign bus.DO      = do_q;
  assign bus.stk_err = ovf_q | udf_q;

endmodule
